// File: rtl/mem_resp_pkg.sv
// Shared definitions for the CPU memory responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: one-hot FSM state codes, latency counter width, and the legal
// latency range together with a helper that checks a latency against it.
package mem_resp_pkg;

  localparam int STATE_W = 5;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE   = 5'b00001;
  localparam state_t ST_I_WAIT = 5'b00010;
  localparam state_t ST_I_RESP = 5'b00100;
  localparam state_t ST_D_WAIT = 5'b01000;
  localparam state_t ST_D_RESP = 5'b10000;

  localparam int LAT_W   = 4;
  localparam int MIN_LAT = 1;
  localparam int MAX_LAT = 15;

  function automatic bit lat_ok(input int lat);
    return (lat >= MIN_LAT) && (lat <= MAX_LAT);
  endfunction

endpackage

// File: rtl/mem_ram_1rw.sv
// Single-port word RAM with per-byte write strobes and a registered read.
// Latency: rdata reflects mem[idx] one edge after a read (en & !we).
// Backpressure: none; the RAM accepts an access every cycle.
//
// Ports: clk; en (access enable); we (1 = write, 0 = read); strb (byte
// enables, bit i -> wdata[8i+7:8i]); idx (word index); wdata; rdata (held
// between reads). Contents are not reset.
module mem_ram_1rw #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [3:0]            strb,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (strb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/cpu_mem_responder.sv
// Target-side responder for the CPU instruction and data channels, both
// served from one shared single-port RAM, one outstanding request at a time.
// Latency: INST_LAT / DATA_LAT cycles from accept to Valid; writes have no
// response. Backpressure: Valid/data hold until Ready; request readies are
// low outside IDLE and during reset.
//
// Ports: clk, rst (sync, active-high); fetch request PC/Inst_Req_Valid/
// Inst_Req_Ready; fetch response Instruction/Inst_Valid/Inst_Ready; data
// request Address/MemWrite/Write_data/Write_strb/MemRead/Mem_Req_Ready;
// load response Read_data/Read_data_Valid/Read_data_Ready.
module cpu_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int INST_LAT   = 2,
  parameter int DATA_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic        Inst_Req_Valid,
  output logic        Inst_Req_Ready,
  output logic [31:0] Instruction,
  output logic        Inst_Valid,
  input  logic        Inst_Ready,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  input  logic        MemRead,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready
);

  localparam logic [LAT_W-1:0] I_LAT = LAT_W'(INST_LAT);
  localparam logic [LAT_W-1:0] D_LAT = LAT_W'(DATA_LAT);
  localparam logic [LAT_W-1:0] ONE   = LAT_W'(1);

  state_t                state;
  state_t                state_nxt;
  logic [LAT_W-1:0]      cnt;
  logic [LAT_W-1:0]      cnt_nxt;
  logic                  cnt_done;

  logic [ADDR_WIDTH-1:0] pc_idx;
  logic [ADDR_WIDTH-1:0] addr_idx;
  logic [ADDR_WIDTH-1:0] idx_q;

  logic                  wr_acc;
  logic                  rd_acc;
  logic                  if_acc;
  logic                  d_load;
  logic                  i_load;

  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic [31:0]           ram_rdata;

  // Last delivered words; presented whenever no response is being shown.
  logic [31:0]           inst_q;
  logic [31:0]           rdata_q;

  logic                  unused_addr_bits;

  assign pc_idx   = PC[ADDR_WIDTH+1:2];
  assign addr_idx = Address[ADDR_WIDTH+1:2];

  // Upper and byte-offset address bits are intentionally ignored (wrap).
  assign unused_addr_bits = ^{PC[31:ADDR_WIDTH+2], PC[1:0],
                              Address[31:ADDR_WIDTH+2], Address[1:0]};

  // Request acceptance. Data requests take priority over fetches, and a
  // simultaneous read+write is handled as a write only.
  assign Mem_Req_Ready  = (state == ST_IDLE) & ~rst;
  assign Inst_Req_Ready = (state == ST_IDLE) & ~rst & ~MemRead & ~MemWrite;

  assign wr_acc = MemWrite & Mem_Req_Ready;
  assign rd_acc = MemRead & ~MemWrite & Mem_Req_Ready;
  assign if_acc = Inst_Req_Valid & Inst_Req_Ready;

  assign cnt_done = (cnt == ONE);

  // RAM read is issued at the edge that must present the response: the
  // accept edge for a latency of 1, otherwise the last WAIT edge.
  assign d_load = (rd_acc & (D_LAT == ONE)) |
                  ((state == ST_D_WAIT) & cnt_done & ~rst);
  assign i_load = (if_acc & (I_LAT == ONE)) |
                  ((state == ST_I_WAIT) & cnt_done & ~rst);

  assign ram_en  = wr_acc | d_load | i_load;
  assign ram_we  = wr_acc;
  assign ram_idx = (state != ST_IDLE)       ? idx_q    :
                   (MemRead | MemWrite)     ? addr_idx : pc_idx;

  mem_ram_1rw #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .strb  (Write_strb),
    .idx   (ram_idx),
    .wdata (Write_data),
    .rdata (ram_rdata)
  );

  // State register and latency counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_acc) idx_q <= addr_idx;
    else if (if_acc) idx_q <= pc_idx;
  end

  // Capture the delivered word at the handshake so the outputs stay put
  // after the response ends, even if a later access reloads the RAM port.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q  <= '0;
      rdata_q <= '0;
    end else begin
      if ((state == ST_I_RESP) && Inst_Ready)      inst_q  <= ram_rdata;
      if ((state == ST_D_RESP) && Read_data_Ready) rdata_q <= ram_rdata;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (rd_acc) begin
          if (D_LAT == ONE) begin
            state_nxt = ST_D_RESP;
          end else begin
            state_nxt = ST_D_WAIT;
            cnt_nxt   = D_LAT - ONE;
          end
        end else if (if_acc) begin
          if (I_LAT == ONE) begin
            state_nxt = ST_I_RESP;
          end else begin
            state_nxt = ST_I_WAIT;
            cnt_nxt   = I_LAT - ONE;
          end
        end
      end
      ST_I_WAIT: begin
        cnt_nxt = cnt - ONE;
        if (cnt_done) state_nxt = ST_I_RESP;
      end
      ST_I_RESP: begin
        if (Inst_Ready) state_nxt = ST_IDLE;
      end
      ST_D_WAIT: begin
        cnt_nxt = cnt - ONE;
        if (cnt_done) state_nxt = ST_D_RESP;
      end
      ST_D_RESP: begin
        if (Read_data_Ready) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs. During a response the RAM read register is shown directly;
  // the RAM is idle in RESP states, so it stays stable until the handshake.
  always_comb begin
    Inst_Valid      = (state == ST_I_RESP);
    Read_data_Valid = (state == ST_D_RESP);
    Instruction     = (state == ST_I_RESP) ? ram_rdata : inst_q;
    Read_data       = (state == ST_D_RESP) ? ram_rdata : rdata_q;
  end

  always @(posedge clk) begin
    assert (lat_ok(INST_LAT) && lat_ok(DATA_LAT));
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder (ADDR_WIDTH=14, INST_LAT=3, DATA_LAT=2).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PC = '0;
  logic        Inst_Req_Valid = 1'b0;
  logic        Inst_Req_Ready;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ready = 1'b1;
  logic [31:0] Address = '0;
  logic        MemWrite = 1'b0;
  logic [31:0] Write_data = '0;
  logic [3:0]  Write_strb = '0;
  logic        MemRead = 1'b0;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_mem_responder #(
    .ADDR_WIDTH (14),
    .INST_LAT   (3),
    .DATA_LAT   (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .PC              (PC),
    .Inst_Req_Valid  (Inst_Req_Valid),
    .Inst_Req_Ready  (Inst_Req_Ready),
    .Instruction     (Instruction),
    .Inst_Valid      (Inst_Valid),
    .Inst_Ready      (Inst_Ready),
    .Address         (Address),
    .MemWrite        (MemWrite),
    .Write_data      (Write_data),
    .Write_strb      (Write_strb),
    .MemRead         (MemRead),
    .Mem_Req_Ready   (Mem_Req_Ready),
    .Read_data       (Read_data),
    .Read_data_Valid (Read_data_Valid),
    .Read_data_Ready (Read_data_Ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // One-cycle write request; no response phase.
  task automatic write_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    Address = a; Write_data = d; Write_strb = s; MemWrite = 1'b1;
    #1 chk("wr_rdy", {31'd0, Mem_Req_Ready}, 32'd1);
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  // Read with DATA_LAT=2 and Read_data_Ready high: Valid in 2nd cycle after
  // the accept cycle, handshake in that cycle, IDLE again the cycle after.
  task automatic read_word(input string tag, input logic [31:0] a, input logic [31:0] exp);
    Address = a; MemRead = 1'b1;
    #1 chk({tag, "_rdy"}, {31'd0, Mem_Req_Ready}, 32'd1);
    @(negedge clk);
    MemRead = 1'b0;
    #1 chk({tag, "_v_early"}, {31'd0, Read_data_Valid}, 32'd0);
    step();
    chk({tag, "_v"}, {31'd0, Read_data_Valid}, 32'd1);
    chk({tag, "_data"}, Read_data, exp);
    step();
    chk({tag, "_v_done"}, {31'd0, Read_data_Valid}, 32'd0);
    chk({tag, "_idle"}, {31'd0, Mem_Req_Ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ivld", {31'd0, Inst_Valid}, 32'd0);
    chk("rst_dvld", {31'd0, Read_data_Valid}, 32'd0);
    chk("rst_inst", Instruction, 32'd0);
    chk("rst_rdata", Read_data, 32'd0);
    chk("rst_mrdy", {31'd0, Mem_Req_Ready}, 32'd0);
    chk("rst_irdy", {31'd0, Inst_Req_Ready}, 32'd0);
    rst = 1'b0;
    #1 chk("idle_mrdy", {31'd0, Mem_Req_Ready}, 32'd1);
    chk("idle_irdy", {31'd0, Inst_Req_Ready}, 32'd1);

    // Full-word write, then back-to-back read of the same word.
    write_word(32'h100, 32'hDEADBEEF, 4'hF);
    read_word("rd100", 32'h100, 32'hDEADBEEF);

    // Byte-strobed writes into a preset word.
    write_word(32'h200, 32'h11223344, 4'hF);
    write_word(32'h200, 32'h000000AA, 4'b0001);
    write_word(32'h200, 32'h0000BB00, 4'b0010);
    read_word("strb", 32'h200, 32'h1122BBAA);

    // Read and write together: stored as a write, no read response.
    MemRead = 1'b1;
    write_word(32'h300, 32'h00000055, 4'hF);
    MemRead = 1'b0;
    #1 chk("rw_norsp0", {31'd0, Read_data_Valid}, 32'd0);
    step();
    chk("rw_norsp1", {31'd0, Read_data_Valid}, 32'd0);
    chk("rw_idle", {31'd0, Mem_Req_Ready}, 32'd1);
    read_word("rw", 32'h300, 32'h00000055);

    // Fetch and load in the same cycle: the load goes first.
    Address = 32'h100; MemRead = 1'b1; PC = 32'h200; Inst_Req_Valid = 1'b1;
    #1 chk("arb_irdy", {31'd0, Inst_Req_Ready}, 32'd0);
    chk("arb_mrdy", {31'd0, Mem_Req_Ready}, 32'd1);
    @(negedge clk);
    MemRead = 1'b0;
    #1 chk("arb_irdy_wait", {31'd0, Inst_Req_Ready}, 32'd0);
    step();
    chk("arb_dvld", {31'd0, Read_data_Valid}, 32'd1);
    chk("arb_data", Read_data, 32'hDEADBEEF);
    chk("arb_irdy_resp", {31'd0, Inst_Req_Ready}, 32'd0);
    step();
    chk("arb_irdy_idle", {31'd0, Inst_Req_Ready}, 32'd1);
    chk("arb_dvld_done", {31'd0, Read_data_Valid}, 32'd0);
    @(negedge clk);
    Inst_Req_Valid = 1'b0;
    #1 chk("arb_ivld_c1", {31'd0, Inst_Valid}, 32'd0);
    step();
    chk("arb_ivld_c2", {31'd0, Inst_Valid}, 32'd0);
    step();
    chk("arb_ivld_c3", {31'd0, Inst_Valid}, 32'd1);
    chk("arb_inst", Instruction, 32'h1122BBAA);
    step();
    chk("arb_ivld_done", {31'd0, Inst_Valid}, 32'd0);

    // Fetch from PC=0 with INST_LAT=3 and the consumer stalling 4 cycles.
    write_word(32'h0, 32'hCAFEF00D, 4'hF);
    PC = 32'h0; Inst_Req_Valid = 1'b1; Inst_Ready = 1'b0;
    #1 chk("stall_irdy", {31'd0, Inst_Req_Ready}, 32'd1);
    @(negedge clk);
    Inst_Req_Valid = 1'b0;
    #1 chk("stall_c1", {31'd0, Inst_Valid}, 32'd0);
    step();
    chk("stall_c2", {31'd0, Inst_Valid}, 32'd0);
    step();
    for (int k = 0; k < 5; k++) begin
      chk("stall_vld", {31'd0, Inst_Valid}, 32'd1);
      chk("stall_inst", Instruction, 32'hCAFEF00D);
      chk("stall_busy", {31'd0, Inst_Req_Ready}, 32'd0);
      if (k == 4) Inst_Ready = 1'b1;
      step();
    end
    chk("stall_vld_done", {31'd0, Inst_Valid}, 32'd0);
    chk("stall_idle", {31'd0, Inst_Req_Ready}, 32'd1);
    chk("stall_inst_held", Instruction, 32'hCAFEF00D);

    // Address aliasing: 0x10000100 maps to word 0x40, same as 0x100.
    read_word("alias", 32'h10000100, 32'hDEADBEEF);

    // Reset while in D_WAIT, with a write held on the bus during reset.
    Address = 32'h100; MemRead = 1'b1;
    @(negedge clk);
    MemRead = 1'b0; rst = 1'b1;
    MemWrite = 1'b1; Write_data = 32'h0; Write_strb = 4'hF;
    #1 chk("mr_mrdy_wait", {31'd0, Mem_Req_Ready}, 32'd0);
    chk("mr_irdy_wait", {31'd0, Inst_Req_Ready}, 32'd0);
    step();
    chk("mr_dvld", {31'd0, Read_data_Valid}, 32'd0);
    chk("mr_rdata", Read_data, 32'd0);
    chk("mr_inst", Instruction, 32'd0);
    chk("mr_mrdy", {31'd0, Mem_Req_Ready}, 32'd0);
    chk("mr_irdy", {31'd0, Inst_Req_Ready}, 32'd0);
    step();
    chk("mr_dvld2", {31'd0, Read_data_Valid}, 32'd0);
    chk("mr_mrdy2", {31'd0, Mem_Req_Ready}, 32'd0);
    rst = 1'b0; MemWrite = 1'b0;
    #1 chk("mr_idle", {31'd0, Mem_Req_Ready}, 32'd1);
    read_word("mr_ram", 32'h100, 32'hDEADBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
